timer_contagem: RTL and testbench
=================================

# timer_contagem

Countdown stage of the oven timer. Sits directly downstream of the keypad/timebase stage and consumes its `D`, `loadn` and `pgt_1Hz` outputs. Key digits are shifted into a four-digit BCD mm:ss register while idle, and the register is decremented once per second while counting is enabled. Its digit outputs drive the display decoders, and `zero`/`done` go to the main control FSM.

## Interface
Parameters:
- `SEC_TENS_MAX`, default 5: value loaded into the seconds-tens digit on a seconds borrow.

Ports:
- `clk100`  in  1  system clock (100 Hz tick domain); all state updates on the rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `D`  in  4  BCD key digit from the keypad stage; valid while `loadn`=0.
- `loadn`  in  1  active-low key-strobe from the keypad stage.
- `pgt_1Hz`  in  1  1 Hz square wave from the keypad/timebase stage; its rising transition is the count tick.
- `enablen`  in  1  active-low count enable from the control FSM (0 = counting, 1 = idle/entry).
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  BCD time digits, registered.
- `zero`  out  1  high when all four digits are 0.
- `done`  out  1  one-cycle pulse on the clock where the count reaches 00:00 by decrement.

## Operation
- **Edge detectors.**
  - `loadn_q` is `loadn` delayed one `clk100` cycle. `ld = ~loadn & loadn_q`, i.e. a falling edge of `loadn`.
  - `pgt_q` is `pgt_1Hz` delayed one cycle. `tick = pgt_1Hz & ~pgt_q`.
  - Only one action occurs per key press or per second, regardless of how long the level is held.
- **Load (entry).** On `ld` with `enablen`=1 and `D` ≤ 9, digits shift left:
  - `min_tens` ← `min_ones`, `min_ones` ← `sec_tens`, `sec_tens` ← `sec_ones`, `sec_ones` ← `D`.
  - The old `min_tens` is discarded.
  - If `D` > 9, the load is ignored.
  - If `enablen`=0, the load is ignored (no editing while counting).
- **Count.** On `tick` with `enablen`=0 and `zero`=0, perform a BCD decrement with borrow chain:
  - If `sec_ones` > 0: `sec_ones`−1.
  - Otherwise `sec_ones`=9, and:
    - if `sec_tens` > 0: `sec_tens`−1;
    - otherwise `sec_tens`=`SEC_TENS_MAX` and borrow into minutes (`min_ones` −1, or `min_ones`=9 with `min_tens`−1).
  - Entered seconds above 59 (e.g. 0:75) are legal. They count down naturally (0:75 → 0:74 …).
- **At zero.**
  - A tick while `zero`=1 leaves the digits at 00:00.
  - `done` does not pulse.
- **Precedence.**
  - `clear` overrides everything.
  - Load and count are mutually exclusive by `enablen`, so they can never be simultaneous.
- `zero` is combinational from the digit registers.
- `done` is registered. It is high for exactly the one cycle following the decrement that produced 00:00.

## Timing
- **Reset.** On a rising edge with `clear`=1:
  - all digits ← 0;
  - `zero` = 1 (follows from digits);
  - `done` = 0;
  - `loadn_q` = 1 and `pgt_q` = 1, so that no spurious `ld`/`tick` occurs on the first cycle after `clear` deasserts.
- **Load latency.** With `loadn` sampled 0 at edge N (and 1 at N−1), the shifted digits are visible after edge N.
- **Tick latency.** With `pgt_1Hz` sampled 1 at edge N (and 0 at N−1), the decremented value is visible after edge N. This gives one decrement per `pgt_1Hz` period (100 `clk100` cycles).
- **Done.** `done` is high in the cycle after the decrementing edge and low on the following edge.
- **Enable gating.** `enablen` is sampled at the same edge as `tick`/`ld`; its value at that edge decides the action.
- **Clear mid-operation.** Asserting `clear` during a count or an entry zeroes the digits at that edge. The pending tick/load is lost.

## Test plan
- **Reset.** Apply `clear`=1 with `pgt_1Hz`=1 for 2 cycles, then release. Required: digits 00:00, `zero`=1, `done`=0, and no decrement or done pulse on the first cycle.
- **Entry.** `enablen`=1; key strobes with `D`=1, 2, 3, 0, each held low 5 cycles. Required: 12:30 after the fourth strobe, one shift per strobe. A fifth strobe with `D`=4 gives 23:04. `D`=10 leaves the value unchanged.
- **Borrow chain.** Load 10:00, `enablen`=0, apply 1 Hz. Required: 09:59 after the first tick, then 09:58. Separately, load 0:75 and count; required: 0:74.
- **Terminal count.** Load 00:02 and count. Required:
  - 00:01 after one tick;
  - 00:00 after the second tick, with `zero`=1 and `done`=1 for exactly one cycle;
  - further ticks hold 00:00 with `done`=0.
- **Locked entry.** With `enablen`=0 during the count, a key strobe with `D`=7 leaves the digits unchanged. Releasing `enablen`=1 then freezes the count.
- **Clear mid-count.** Assert `clear` for one cycle at 05:17. Required: 00:00 on the next edge and `done` stays 0.

Source files
------------

// File: rtl/timer_contagem.sv
// ---------------------------------------------------------------------------
// timer_contagem - countdown stage of the oven timer
//
// Holds a four-digit BCD mm:ss value. While idle (enablen=1) each falling
// edge of the key strobe shifts a new digit in from the right. While
// counting (enablen=0) each rising edge of the 1 Hz wave decrements the
// value by one second, stopping at 00:00.
//
// Ports:
//   clk100    in   system clock, all state changes on the rising edge
//   clear     in   synchronous active-high reset
//   D         in   BCD key digit, valid while loadn=0
//   loadn     in   active-low key strobe
//   pgt_1Hz   in   1 Hz square wave, rising transition is the count tick
//   enablen   in   active-low count enable (0 = counting, 1 = entry)
//   min_tens, min_ones, sec_tens, sec_ones  out  registered BCD digits
//   zero      out  all four digits are 0 (combinational from registers)
//   done      out  one-cycle pulse after the decrement that reached 00:00
// ---------------------------------------------------------------------------
module timer_contagem #(
    parameter int unsigned SEC_TENS_MAX = 5
) (
    input  logic       clk100,
    input  logic       clear,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       enablen,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       zero,
    output logic       done
);

    // Digit index 0 = sec_ones, 1 = sec_tens, 2 = min_ones, 3 = min_tens
    logic [3:0] digit_reg  [4];
    logic [3:0] digit_next [4];
    logic [3:0] shift_val  [4];
    logic [3:0] dec_val    [4];
    logic       borrow     [5];

    logic loadn_q_reg;
    logic pgt_q_reg;
    logic done_reg;
    logic done_next;

    logic ld;
    logic tick;
    logic do_load;
    logic do_count;
    logic dec_is_zero;

    // One action per key press / per second, whatever the level duration
    assign ld   = ~loadn & loadn_q_reg;
    assign tick = pgt_1Hz & ~pgt_q_reg;

    assign zero = (digit_reg[0] == 4'd0) && (digit_reg[1] == 4'd0) &&
                  (digit_reg[2] == 4'd0) && (digit_reg[3] == 4'd0);

    assign do_load  = ld & enablen & (D <= 4'd9);
    assign do_count = tick & ~enablen & ~zero;

    // Shift-left path: new key enters at sec_ones, old min_tens falls off
    assign shift_val[0] = D;

    // Borrow chain: the lowest digit always receives a borrow; a digit
    // passes the borrow on only when it is 0 and must wrap.
    assign borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            // Seconds-tens wraps to SEC_TENS_MAX, every other digit to 9
            localparam logic [3:0] WRAP = (gi == 1) ? SEC_TENS_MAX[3:0] : 4'd9;

            assign borrow[gi+1] = borrow[gi] & (digit_reg[gi] == 4'd0);

            assign dec_val[gi] = !borrow[gi]              ? digit_reg[gi] :
                                 (digit_reg[gi] == 4'd0)  ? WRAP :
                                                            digit_reg[gi] - 4'd1;

            if (gi > 0) begin : g_shift
                assign shift_val[gi] = digit_reg[gi-1];
            end
        end
    endgenerate

    assign dec_is_zero = (dec_val[0] == 4'd0) && (dec_val[1] == 4'd0) &&
                         (dec_val[2] == 4'd0) && (dec_val[3] == 4'd0);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            digit_next[i] = digit_reg[i];
        end
        done_next = 1'b0;
        if (do_load) begin
            for (int i = 0; i < 4; i++) begin
                digit_next[i] = shift_val[i];
            end
        end else if (do_count) begin
            for (int i = 0; i < 4; i++) begin
                digit_next[i] = dec_val[i];
            end
            done_next = dec_is_zero;
        end
    end

    always_ff @(posedge clk100) begin
        if (clear) begin
            for (int i = 0; i < 4; i++) begin
                digit_reg[i] <= 4'd0;
            end
            // Delayed copies preset high so release of clear never looks
            // like a strobe or a tick.
            loadn_q_reg <= 1'b1;
            pgt_q_reg   <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                digit_reg[i] <= digit_next[i];
            end
            loadn_q_reg <= loadn;
            pgt_q_reg   <= pgt_1Hz;
            done_reg    <= done_next;
        end
    end

    assign sec_ones = digit_reg[0];
    assign sec_tens = digit_reg[1];
    assign min_ones = digit_reg[2];
    assign min_tens = digit_reg[3];
    assign done     = done_reg;

endmodule

// File: tb/tb_timer_contagem.sv
// ---------------------------------------------------------------------------
// tb_timer_contagem - directed self-checking bench for timer_contagem
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_timer_contagem;

    logic       clk100 = 1'b0;
    logic       clear;
    logic [3:0] D;
    logic       loadn;
    logic       pgt_1Hz;
    logic       enablen;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       zero;
    logic       done;

    logic [15:0] t;
    assign t = {min_tens, min_ones, sec_tens, sec_ones};

    int n_checks = 0;
    int n_fail   = 0;

    int   done_cnt;
    logic done_first;

    timer_contagem #(.SEC_TENS_MAX(5)) dut (
        .clk100   (clk100),
        .clear    (clear),
        .D        (D),
        .loadn    (loadn),
        .pgt_1Hz  (pgt_1Hz),
        .enablen  (enablen),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .zero     (zero),
        .done     (done)
    );

    always #5 clk100 = ~clk100;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk100);
        #1;
    endtask

    // One key press: strobe held low 5 cycles, then 2 idle cycles
    task automatic key(input logic [3:0] d);
        D     = d;
        loadn = 1'b0;
        step(5);
        loadn = 1'b1;
        step(2);
    endtask

    task automatic load4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] e);
        key(a);
        key(b);
        key(c);
        key(e);
    endtask

    // One full 1 Hz period (100 cycles). done_first is done right after the
    // rising edge; done_cnt counts cycles with done=1 over the period.
    task automatic one_second(output int cnt, output logic first);
        pgt_1Hz = 1'b1;
        step(1);
        first = done;
        cnt   = 0;
        for (int i = 0; i < 99; i++) begin
            if (done) cnt++;
            if (i == 49) pgt_1Hz = 1'b0;
            step(1);
        end
    endtask

    initial begin
        clear   = 1'b1;
        pgt_1Hz = 1'b1;
        loadn   = 1'b1;
        enablen = 1'b1;
        D       = 4'd0;
        step(2);
        check("reset_digits", t, 16'h0000);
        check("reset_zero", zero, 1);
        check("reset_done", done, 0);

        // Release with pgt_1Hz still high: no tick may be seen
        clear = 1'b0;
        step(1);
        check("post_reset_digits", t, 16'h0000);
        check("post_reset_done", done, 0);
        pgt_1Hz = 1'b0;
        step(3);

        // Entry
        key(4'd1); check("entry_1", t, 16'h0001);
        check("entry_nonzero", zero, 0);
        key(4'd2); check("entry_2", t, 16'h0012);
        key(4'd3); check("entry_3", t, 16'h0123);
        key(4'd0); check("entry_4", t, 16'h1230);
        key(4'd4); check("entry_5", t, 16'h2304);
        key(4'd10); check("entry_invalid", t, 16'h2304);

        // Borrow chain 10:00 -> 09:59 -> 09:58
        load4(4'd1, 4'd0, 4'd0, 4'd0);
        check("load_1000", t, 16'h1000);
        enablen = 1'b0;
        step(1);
        one_second(done_cnt, done_first);
        check("borrow_0959", t, 16'h0959);
        one_second(done_cnt, done_first);
        check("borrow_0958", t, 16'h0958);
        enablen = 1'b1;
        step(1);

        // Seconds above 59
        load4(4'd0, 4'd0, 4'd7, 4'd5);
        check("load_0075", t, 16'h0075);
        enablen = 1'b0;
        step(1);
        one_second(done_cnt, done_first);
        check("count_0074", t, 16'h0074);
        enablen = 1'b1;
        step(1);

        // Terminal count
        load4(4'd0, 4'd0, 4'd0, 4'd2);
        check("load_0002", t, 16'h0002);
        enablen = 1'b0;
        step(1);
        one_second(done_cnt, done_first);
        check("term_0001", t, 16'h0001);
        check("term_0001_done", done_cnt, 0);
        one_second(done_cnt, done_first);
        check("term_0000", t, 16'h0000);
        check("term_zero", zero, 1);
        check("term_done_first", done_first, 1);
        check("term_done_width", done_cnt, 1);
        one_second(done_cnt, done_first);
        check("hold_0000", t, 16'h0000);
        check("hold_done_first", done_first, 0);
        check("hold_done_cnt", done_cnt, 0);
        enablen = 1'b1;
        step(1);

        // Locked entry while counting, then freeze
        load4(4'd0, 4'd0, 4'd0, 4'd9);
        check("load_0009", t, 16'h0009);
        enablen = 1'b0;
        step(1);
        key(4'd7);
        check("locked_entry", t, 16'h0009);
        one_second(done_cnt, done_first);
        check("locked_count", t, 16'h0008);
        enablen = 1'b1;
        step(1);
        one_second(done_cnt, done_first);
        check("frozen", t, 16'h0008);

        // Clear mid-count, coincident with a tick
        load4(4'd0, 4'd5, 4'd1, 4'd7);
        check("load_0517", t, 16'h0517);
        enablen = 1'b0;
        step(1);
        clear   = 1'b1;
        pgt_1Hz = 1'b1;
        step(1);
        clear = 1'b0;
        check("clear_digits", t, 16'h0000);
        check("clear_done", done, 0);
        done_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 30) pgt_1Hz = 1'b0;
            step(1);
            if (done) done_cnt++;
        end
        check("clear_no_done", done_cnt, 0);
        check("clear_hold", t, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
